int_sequencer: RTL and testbench
================================

Name: int_sequencer

Overview:
Interrupt/exception sequencer sitting between peripheral IRQ lines, the commit stage of the pipeline and CP0. It conditions raw IRQs into CP0 HWInt, decides the retiring instruction at which an interrupt is taken, and pulses CP0 EXLSet/EXLClr. It also drives the CP0 PC input and issues the flush and redirect to the handler on entry and to EPC on eret.

Parameters:
NSRC, 6, number of hardware interrupt sources (matches CP0 HWInt width)
HANDLER_ADDR, 32'h0000_4180, byte address of the interrupt handler
EDGE_MASK, 6'b000000, per source: 1 = rising-edge latched, 0 = level

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
irq_in  in  NSRC  raw peripheral interrupt lines, asynchronous to clk
irq_clr  in  NSRC  one-cycle clear pulses for latched edge sources
IntReq  in  1  interrupt request from CP0
EPC  in  30  CP0 EPC (PC[31:2])
instr_valid  in  1  commit-stage instruction is valid
commit_pc  in  30  PC[31:2] of the commit-stage instruction
is_eret  in  1  commit-stage instruction is eret
pipe_stall  in  1  commit stage is stalled this cycle
HWInt  out  NSRC  conditioned interrupt lines to CP0
EXLSet  out  1  CP0 EXL set pulse
EXLClr  out  1  CP0 EXL clear pulse
PC  out  30  PC to CP0, captured into EPC when EXLSet=1
flush  out  1  kill all younger pipeline contents
redirect  out  1  fetch-PC override valid
redirect_pc  out  32  fetch-PC override value
in_handler  out  1  high while in TAKE or HANDLER

Behaviour:
- Reset (reset=0) applies immediately, from any state. State goes to RUN. All synchroniser, edge and pending flops clear to 0. All outputs are 0, including redirect_pc and PC.
- IRQ conditioning, per source i:
  - irq_in passes through a 2-flop synchroniser, giving s2.
  - Level source: HWInt[i] = s2. A rise in the sample at edge k is visible at HWInt after edge k+2.
  - Edge source: rise = s2 & ~prev. The rise sets pending[i] and HWInt[i] = pending[i], visible after edge k+3.
  - pending[i] is cleared by irq_clr[i]. If a rise and irq_clr[i] occur in the same cycle, the set wins.
  - irq_clr on a level source is ignored.
- FSM states: RUN, TAKE, HANDLER, RET. All outputs are registered.
- RUN: if IntReq & instr_valid & ~pipe_stall, latch commit_pc and go to TAKE.
  - is_eret in RUN is ignored (no redirect or EXL action).
- TAKE (exactly 1 cycle, not held by pipe_stall):
  - EXLSet=1, PC=latched commit_pc, flush=1, redirect=1, redirect_pc=HANDLER_ADDR.
  - Next state is HANDLER.
  - The interrupted instruction is not committed; EPC points at it.
- HANDLER: if is_eret & instr_valid & ~pipe_stall, go to RET.
  - IntReq is ignored (CP0 EXL masks it).
- RET (exactly 1 cycle):
  - EXLClr=1, flush=1, redirect=1, redirect_pc={EPC,2'b00}.
  - Next state is RUN.
  - A pending interrupt may be taken at the very next valid commit, including the eret target.
- EXLSet, EXLClr, flush and redirect are single-cycle pulses and are 0 in RUN and HANDLER.
- PC holds its last value outside TAKE.
- EXLSet and EXLClr are never both 1.
- pipe_stall freezes only the RUN and HANDLER decisions. It does not extend TAKE or RET.
- Reset in TAKE or RET aborts the pulse in the same cycle. CP0 is reset by the same signal.

Decomposition:
- Shared package: state encodings (RUN=2'd0, TAKE=2'd1, HANDLER=2'd2, RET=2'd3), HANDLER_ADDR default, and the EXL lock/unlock constants already used by CP0.
- One sub-module, irq_cond: an NSRC-wide synchroniser plus edge-detect and pending array, parameterised by EDGE_MASK.
- The FSM and output registers stay in int_sequencer.

Test Plan:
1. Reset check: hold reset=0 mid-stream with irq_in=6'h3f -> all outputs 0 and in_handler=0. After release with irq_in=0, HWInt stays 6'h00.
2. Level IRQ latency: EDGE_MASK=0, raise irq_in[2] just after edge k -> HWInt=6'b000100 after edge k+2. Drop irq_in[2] -> HWInt returns to 0 two edges later.
3. Edge IRQ with clear: EDGE_MASK=6'b000001, pulse irq_in[0] for 1 cycle -> HWInt[0]=1 from edge k+3 and held. Apply irq_clr[0] -> HWInt[0]=0 next edge. A rise coinciding with the clear -> stays 1.
4. Interrupt entry: in RUN, IntReq=1, instr_valid=1, commit_pc=30'h0000_0C05, pipe_stall=0 -> next cycle EXLSet=1, PC=30'h0000_0C05, flush=1, redirect_pc=32'h0000_4180. One cycle later all pulses are 0 and in_handler=1.
5. Stall and eret: in HANDLER with pipe_stall=1 and is_eret=1 for 3 cycles -> no action. Drop the stall with EPC=30'h0000_0C05 -> next cycle EXLClr=1, redirect_pc=32'h0000_3014, state RUN.
6. Spurious eret in RUN: is_eret=1, IntReq=0 -> no redirect, EXLClr=0. With IntReq=1 and is_eret=1 together -> the interrupt is taken (TAKE sequence as in scenario 4).

Source files
------------

// File: rtl/int_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer and its IRQ conditioner.
package int_sequencer_pkg;

  localparam int NSRC_DEFAULT = 6;
  localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

  // Sequencer states, encodings fixed so CP0-side debug views decode them directly.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RET     = 2'd3
  } seq_state_t;

  // EXL actions as CP0 sees them: lock on entry, unlock on eret, otherwise hold.
  typedef enum logic [1:0] {
    EXL_HOLD   = 2'd0,
    EXL_LOCK   = 2'd1,
    EXL_UNLOCK = 2'd2
  } exl_op_t;

  // Everything the sequencer drives, kept together so it is registered as one bundle.
  typedef struct packed {
    exl_op_t     exl_op;
    logic        flush;
    logic        redirect;
    logic        in_handler;
    logic [29:0] pc;
    logic [31:0] redirect_pc;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RESET = '0;

endpackage

// File: rtl/int_sequencer_irq_cond.sv
// IRQ conditioning: 2-flop synchroniser per source, then either a level
// pass-through or a rising-edge detector feeding a sticky pending bit.
module irq_cond
  import int_sequencer_pkg::*;
#(
  parameter int              NSRC      = NSRC_DEFAULT,
  parameter logic [NSRC-1:0] EDGE_MASK = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] irq_clr,
  output logic [NSRC-1:0] hw_int
);

  logic [NSRC-1:0] s1;
  logic [NSRC-1:0] s2;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] rise;

  // Synchronise the asynchronous peripheral lines into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse s1/s2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
    end
  end

  // Only edge-configured sources can ever see a rise or hold a pending bit.
  assign rise = s2 & ~prev & EDGE_MASK;

  // Edge history and pending latch; a new rise beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= s2;
      pending <= (pending & ~(irq_clr & EDGE_MASK)) | rise;
    end
  end

  // Both candidates are flop outputs, so the selected line is glitch-free.
  assign hw_int = (pending & EDGE_MASK) | (s2 & ~EDGE_MASK);

endmodule

// File: rtl/int_sequencer.sv
// Interrupt/exception sequencer: conditions IRQs for CP0, picks the commit
// point for interrupt entry, pulses EXL set/clear and redirects fetch.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter int              NSRC         = NSRC_DEFAULT,
  parameter logic [31:0]     HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
  parameter logic [NSRC-1:0] EDGE_MASK    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [NSRC-1:0] irq_clr,
  input  logic            IntReq,
  input  logic [29:0]     EPC,
  input  logic            instr_valid,
  input  logic [29:0]     commit_pc,
  input  logic            is_eret,
  input  logic            pipe_stall,
  output logic [NSRC-1:0] HWInt,
  output logic            EXLSet,
  output logic            EXLClr,
  output logic [29:0]     PC,
  output logic            flush,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic            in_handler
);

  seq_state_t state_q, state_d;
  seq_out_t   out_q, out_d;

  irq_cond #(
    .NSRC      (NSRC),
    .EDGE_MASK (EDGE_MASK)
  ) u_irq_cond (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .irq_clr (irq_clr),
    .hw_int  (HWInt)
  );

  // Next-state and next-output decision; outputs take effect the cycle the
  // new state is entered, so TAKE and RET each produce a one-cycle pulse.
  // NOTE: every signal written here gets a default first, otherwise any
  // branch that skips an assignment would infer a latch.
  always_comb begin
    state_d          = state_q;
    out_d            = out_q;
    out_d.exl_op     = EXL_HOLD;
    out_d.flush      = 1'b0;
    out_d.redirect   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (IntReq && instr_valid && !pipe_stall) begin
          state_d           = TAKE;
          out_d.exl_op      = EXL_LOCK;
          out_d.flush       = 1'b1;
          out_d.redirect    = 1'b1;
          out_d.pc          = commit_pc;
          out_d.redirect_pc = HANDLER_ADDR;
        end
      end
      TAKE: begin
        state_d = HANDLER;
      end
      HANDLER: begin
        // IntReq is masked by CP0 EXL here, only eret matters.
        if (is_eret && instr_valid && !pipe_stall) begin
          state_d           = RET;
          out_d.exl_op      = EXL_UNLOCK;
          out_d.flush       = 1'b1;
          out_d.redirect    = 1'b1;
          out_d.redirect_pc = {EPC, 2'b00};
        end
      end
      RET: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    out_d.in_handler = (state_d == TAKE) || (state_d == HANDLER);
  end

  // State and output registers; reset aborts any pulse in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      out_q   <= SEQ_OUT_RESET;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // A single encoded EXL action makes simultaneous set and clear impossible.
  assign EXLSet      = (out_q.exl_op == EXL_LOCK);
  assign EXLClr      = (out_q.exl_op == EXL_UNLOCK);
  assign PC          = out_q.pc;
  assign flush       = out_q.flush;
  assign redirect    = out_q.redirect;
  assign redirect_pc = out_q.redirect_pc;
  assign in_handler  = out_q.in_handler;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: source 0 is edge-latched, sources 1-5 level.
module tb_int_sequencer;

  localparam int NSRC = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [NSRC-1:0] irq_clr;
  logic            IntReq;
  logic [29:0]     EPC;
  logic            instr_valid;
  logic [29:0]     commit_pc;
  logic            is_eret;
  logic            pipe_stall;
  logic [NSRC-1:0] HWInt;
  logic            EXLSet;
  logic            EXLClr;
  logic [29:0]     PC;
  logic            flush;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic            in_handler;

  int checks = 0;
  int errors = 0;

  int_sequencer #(
    .NSRC         (NSRC),
    .HANDLER_ADDR (32'h0000_4180),
    .EDGE_MASK    (6'b000001)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .irq_clr     (irq_clr),
    .IntReq      (IntReq),
    .EPC         (EPC),
    .instr_valid (instr_valid),
    .commit_pc   (commit_pc),
    .is_eret     (is_eret),
    .pipe_stall  (pipe_stall),
    .HWInt       (HWInt),
    .EXLSet      (EXLSet),
    .EXLClr      (EXLClr),
    .PC          (PC),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_handler  (in_handler)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then step off it so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_exlset"}, 32'(EXLSet), 32'd0);
    check({tag, "_exlclr"}, 32'(EXLClr), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redirect"}, 32'(redirect), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    irq_in      = 6'h3f;
    irq_clr     = '0;
    IntReq      = 1'b0;
    EPC         = '0;
    instr_valid = 1'b0;
    commit_pc   = '0;
    is_eret     = 1'b0;
    pipe_stall  = 1'b0;

    // 1. reset with all IRQs high
    tick(); tick(); tick();
    check("rst_hwint", 32'(HWInt), 32'h0);
    check_quiet("rst");
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);
    check("rst_inh", 32'(in_handler), 32'd0);
    irq_in = '0;
    reset  = 1'b1;
    tick(); tick(); tick(); tick();
    check("post_rst_hwint", 32'(HWInt), 32'h0);

    // 2. level IRQ on source 2, raised just after edge k
    irq_in = 6'b000100;
    tick();
    check("lvl_k1", 32'(HWInt), 32'h0);
    tick();
    check("lvl_k2", 32'(HWInt), 32'h04);
    irq_in = '0;
    tick();
    check("lvl_drop1", 32'(HWInt), 32'h04);
    tick();
    check("lvl_drop2", 32'(HWInt), 32'h0);

    // 3. edge IRQ on source 0: one-cycle pulse, latched until cleared
    irq_in = 6'b000001;
    tick();
    irq_in = '0;
    tick();
    check("edge_k2", 32'(HWInt), 32'h0);
    tick();
    check("edge_k3", 32'(HWInt), 32'h01);
    tick(); tick(); tick();
    check("edge_held", 32'(HWInt), 32'h01);
    irq_clr = 6'b000001;
    tick();
    irq_clr = '0;
    check("edge_clr", 32'(HWInt), 32'h0);
    // re-latch, then a second rise coincides with a clear: set wins
    irq_in = 6'b000001;
    tick();
    irq_in = '0;
    tick(); tick();
    check("edge_relatch", 32'(HWInt), 32'h01);
    irq_in = 6'b000001;
    tick();
    irq_in = '0;
    tick();
    irq_clr = 6'b000001;
    tick();
    irq_clr = '0;
    check("edge_set_wins", 32'(HWInt), 32'h01);
    tick();
    check("edge_set_wins_hold", 32'(HWInt), 32'h01);
    irq_clr = 6'b000001;
    tick();
    irq_clr = '0;
    check("edge_final_clr", 32'(HWInt), 32'h0);

    // 4. interrupt entry
    IntReq      = 1'b1;
    instr_valid = 1'b1;
    commit_pc   = 30'h0000_0C05;
    tick();
    IntReq      = 1'b0;
    instr_valid = 1'b0;
    check("take_exlset", 32'(EXLSet), 32'd1);
    check("take_exlclr", 32'(EXLClr), 32'd0);
    check("take_pc", 32'(PC), 32'h0000_0C05);
    check("take_flush", 32'(flush), 32'd1);
    check("take_redirect", 32'(redirect), 32'd1);
    check("take_rpc", redirect_pc, 32'h0000_4180);
    check("take_inh", 32'(in_handler), 32'd1);
    tick();
    check_quiet("hdl");
    check("hdl_inh", 32'(in_handler), 32'd1);
    check("hdl_pc_hold", 32'(PC), 32'h0000_0C05);

    // IntReq in HANDLER is ignored
    IntReq      = 1'b1;
    instr_valid = 1'b1;
    commit_pc   = 30'h0000_0777;
    tick();
    check_quiet("hdl_intreq");
    check("hdl_intreq_pc", 32'(PC), 32'h0000_0C05);
    IntReq = 1'b0;

    // 5. stalled eret does nothing, then fires once the stall drops
    EPC        = 30'h0000_0C05;
    is_eret    = 1'b1;
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("stall_eret");
      check("stall_inh", 32'(in_handler), 32'd1);
    end
    pipe_stall = 1'b0;
    tick();
    is_eret     = 1'b0;
    instr_valid = 1'b0;
    check("ret_exlclr", 32'(EXLClr), 32'd1);
    check("ret_exlset", 32'(EXLSet), 32'd0);
    check("ret_flush", 32'(flush), 32'd1);
    check("ret_redirect", 32'(redirect), 32'd1);
    check("ret_rpc", redirect_pc, 32'h0000_3014);
    check("ret_inh", 32'(in_handler), 32'd0);
    tick();
    check_quiet("run_after_ret");
    check("run_pc_hold", 32'(PC), 32'h0000_0C05);

    // 6. eret in RUN is ignored; eret plus IntReq takes the interrupt
    is_eret     = 1'b1;
    instr_valid = 1'b1;
    tick(); tick();
    check_quiet("spurious_eret");
    check("spurious_inh", 32'(in_handler), 32'd0);
    IntReq    = 1'b1;
    commit_pc = 30'h0000_1234;
    tick();
    IntReq      = 1'b0;
    is_eret     = 1'b0;
    instr_valid = 1'b0;
    check("take2_exlset", 32'(EXLSet), 32'd1);
    check("take2_exlclr", 32'(EXLClr), 32'd0);
    check("take2_pc", 32'(PC), 32'h0000_1234);
    check("take2_rpc", redirect_pc, 32'h0000_4180);
    check("take2_flush", 32'(flush), 32'd1);
    tick();
    check("hdl2_inh", 32'(in_handler), 32'd1);

    // reset asserted in RET aborts the pulse immediately
    EPC         = 30'h0000_0100;
    is_eret     = 1'b1;
    instr_valid = 1'b1;
    tick();
    is_eret     = 1'b0;
    instr_valid = 1'b0;
    check("ret2_exlclr", 32'(EXLClr), 32'd1);
    check("ret2_rpc", redirect_pc, 32'h0000_0400);
    reset = 1'b0;
    #1;
    check_quiet("abort");
    check("abort_pc", 32'(PC), 32'h0);
    check("abort_rpc", redirect_pc, 32'h0);
    check("abort_inh", 32'(in_handler), 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check_quiet("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
